neuron_buffer_ctrl: RTL and testbench
=====================================

# neuron_buffer_ctrl

Sequencer and arbiter for one neuron buffer. It shares the buffer between two requesters: the host load/unload port, which moves one W-bit word per bank, and the convolution unit, which runs burst row reads and single row write-backs at D×W bits per row. It drives the buffer's wide port, its write strobe, its row address and its packed IO control word, and returns the buffer's read data to whichever requester owns the access.

## Interface
- depth, 2, log2 of convolution-unit size
- A, 7, row address width
- W, 16, word width
- D, 1<<depth, banks per row
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- host_req  in  1  host single-word access request, held until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  A  host row address
- host_bank  in  depth  host bank select
- host_wdata  in  W  host write word
- host_gnt  out  1  host access issued this cycle
- host_rvalid  out  1  host_rdata valid
- host_rdata  out  W  host read word
- conv_start  in  1  burst-read start pulse
- conv_base  in  A  burst first row, sampled on accepted start
- conv_len  in  A+1  burst row count, 0..2^A, sampled on accepted start
- conv_busy  out  1  burst in progress
- conv_valid  out  1  conv_data valid
- conv_data  out  W*D  burst row data
- conv_done  out  1  one-cycle pulse, burst complete
- conv_wr  in  1  row write-back request, held until acked
- conv_wr_addr  in  A  write-back row
- conv_wr_data  in  W*D  write-back row data
- conv_wr_ack  out  1  write-back issued this cycle
- buf_ip  out  W*D  buffer wide write data
- buf_write  out  1  buffer write strobe
- buf_address  out  A  buffer row address
- buf_ioInputs  out  W+depth+2  {ioSelect, iow, ioBankSelect, ioInput}
- buf_op  in  W*D  buffer wide read data
- buf_ioOutputs  in  W  buffer IO read word

## Operation
- The buffer is synchronous. It samples address, write and IO controls on the CLK edge and presents read data in the following cycle.
- States:
  - IDLE, BURST, FLUSH.
  - The state and the burst counter/address are registers.
  - Buffer drive, host_gnt and conv_wr_ack are combinational from the state and the requests.
- IDLE priority, highest first: conv_wr, conv_start, host_req. Exactly one request is served per cycle.
  - conv_wr: conv_wr_ack=1, buf_write=1, buf_address=conv_wr_addr, buf_ip=conv_wr_data, ioSelect=0. Stay in IDLE.
  - conv_start, conv_len≠0: latch base and len, issue row base this cycle (ioSelect=0, buf_write=0), set remaining=len−1. Go to BURST if remaining≠0, otherwise FLUSH.
  - conv_start, conv_len=0: no buffer access, go to FLUSH. Produces a conv_done pulse with no conv_valid.
  - host_req: host_gnt=1, buf_address=host_addr, ioSelect=1, iow=host_we, ioBankSelect=host_bank, ioInput=host_wdata. buf_write=host_we.
- BURST: issue row base+i, where i counts up from 1. The address wraps modulo 2^A: base 126, len 4 gives rows 126, 127, 0, 1. Decrement remaining each cycle and go to FLUSH after the last row is issued. All requests stall.
- FLUSH: no buffer access. Requests stall. Return to IDLE next cycle.
- conv_busy=1 from the cycle after start is accepted through the FLUSH cycle.
- conv_start outside IDLE is ignored and not queued. conv_wr and host_req outside IDLE stay pending.
- conv_data = buf_op and host_rdata = buf_ioOutputs, passed through.
- When idle, buf_ioInputs = 0, buf_write = 0 and buf_address = 0.

## Timing
- Reset values:
  - state IDLE, counters 0.
  - host_gnt, host_rvalid, conv_busy, conv_valid, conv_done, conv_wr_ack and buf_write are 0.
  - buf_address and buf_ioInputs are 0.
- Reset asserted mid-burst aborts the burst: no further conv_valid and no conv_done.
- Host write: completes at the edge ending the grant cycle.
- Host read: host_rvalid pulses one cycle after host_gnt with the read word.
- Burst: conv_valid is high N consecutive cycles, starting the cycle after the start is accepted.
- conv_done is high in the FLUSH cycle. For len≠0 that is the cycle carrying the last conv_valid. For len=0 it is the cycle after the start.
- A burst of N rows occupies the buffer N+1 cycles, including FLUSH.
- Host worst-case wait is 2^A+1 cycles plus any back-to-back conv_wr traffic. Host starvation under continuous conv_wr is accepted.

## Test plan
- Host write then read: write 0xBEEF to row 5 bank 2, then read row 5 bank 2. Required: host_gnt each cycle, ioInputs = {1,1,2,0xBEEF}, host_rvalid one cycle after the read grant with host_rdata=0xBEEF.
- Burst: conv_wr rows 10..13 with distinct patterns, then conv_start base=10 len=4. Required: conv_valid for 4 cycles with the rows in order, conv_done on the 4th, conv_busy 4 cycles.
- Wrap and zero length: base=126 len=4 gives addresses 126, 127, 0, 1. len=0 gives conv_done one cycle later with no conv_valid and no buffer access.
- Simultaneous requests in IDLE: conv_wr, conv_start and host_req together. Required order: conv_wr_ack cycle 0, burst starts cycle 1, host_gnt only after FLUSH.
- Contention: host_req and a second conv_start during the burst. Required: host_gnt stays low until the return to IDLE, the second start is dropped, no extra conv_done.
- Reset: drive RST_N low during row 2 of an 8-row burst. Required: all outputs 0 asynchronously, no conv_done, and a new burst after release runs normally.

Source files
------------

// File: rtl/neuron_buffer_ctrl.sv
// rtl/neuron_buffer_ctrl.sv - neuron buffer sequencer: conv burst reads, conv write-backs, host word access
// Fixed-priority arbiter in IDLE; BURST streams rows, FLUSH drains the last read.
module neuron_buffer_ctrl #(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int W     = 16,
  parameter int D     = 1 << depth
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [A-1:0]         host_addr,
  input  logic [depth-1:0]     host_bank,
  input  logic [W-1:0]         host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [W-1:0]         host_rdata,
  input  logic                 conv_start,
  input  logic [A-1:0]         conv_base,
  input  logic [A:0]           conv_len,
  output logic                 conv_busy,
  output logic                 conv_valid,
  output logic [W*D-1:0]       conv_data,
  output logic                 conv_done,
  input  logic                 conv_wr,
  input  logic [A-1:0]         conv_wr_addr,
  input  logic [W*D-1:0]       conv_wr_data,
  output logic                 conv_wr_ack,
  output logic [W*D-1:0]       buf_ip,
  output logic                 buf_write,
  output logic [A-1:0]         buf_address,
  output logic [W+depth+1:0]   buf_ioInputs,
  input  logic [W*D-1:0]       buf_op,
  input  logic [W-1:0]         buf_ioOutputs
);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

  state_t           state;
  logic [A-1:0]     next_addr;
  logic [A:0]       remaining;

  logic             serve_wr;
  logic             serve_start;
  logic             serve_host;
  logic             burst_issue;
  logic             io_sel;
  logic             io_we;
  logic [depth-1:0] io_bank;
  logic [W-1:0]     io_in;

  // Reset gates the arbiter so request-driven outputs drop to zero asynchronously.
  always_comb begin
    serve_wr    = 1'b0;
    serve_start = 1'b0;
    serve_host  = 1'b0;
    if (RST_N && state == IDLE) begin
      if (conv_wr)         serve_wr    = 1'b1;
      else if (conv_start) serve_start = 1'b1;
      else if (host_req)   serve_host  = 1'b1;
    end
  end

  always_comb begin
    buf_write   = 1'b0;
    buf_address = '0;
    buf_ip      = '0;
    io_sel      = 1'b0;
    io_we       = 1'b0;
    io_bank     = '0;
    io_in       = '0;
    host_gnt    = 1'b0;
    conv_wr_ack = 1'b0;
    burst_issue = 1'b0;
    if (serve_wr) begin
      conv_wr_ack = 1'b1;
      buf_write   = 1'b1;
      buf_address = conv_wr_addr;
      buf_ip      = conv_wr_data;
    end else if (serve_start) begin
      if (conv_len != '0) begin
        buf_address = conv_base;
        burst_issue = 1'b1;
      end
    end else if (serve_host) begin
      host_gnt    = 1'b1;
      buf_write   = host_we;
      buf_address = host_addr;
      io_sel      = 1'b1;
      io_we       = host_we;
      io_bank     = host_bank;
      io_in       = host_wdata;
    end else if (RST_N && state == BURST) begin
      buf_address = next_addr;
      burst_issue = 1'b1;
    end
  end

  assign buf_ioInputs = {io_sel, io_we, io_bank, io_in};
  assign conv_data    = buf_op;
  assign host_rdata   = buf_ioOutputs;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      next_addr   <= '0;
      remaining   <= '0;
      host_rvalid <= 1'b0;
      conv_valid  <= 1'b0;
      conv_busy   <= 1'b0;
      conv_done   <= 1'b0;
    end else begin
      host_rvalid <= host_gnt & ~host_we;
      conv_valid  <= burst_issue;
      conv_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (serve_start) begin
            conv_busy <= 1'b1;
            next_addr <= conv_base + A'(1);
            if (conv_len == '0) begin
              remaining <= '0;
              state     <= FLUSH;
              conv_done <= 1'b1;
            end else begin
              remaining <= conv_len - (A+1)'(1);
              if (conv_len == (A+1)'(1)) begin
                state     <= FLUSH;
                conv_done <= 1'b1;
              end else begin
                state     <= BURST;
              end
            end
          end
        end
        BURST: begin
          next_addr <= next_addr + A'(1);
          remaining <= remaining - (A+1)'(1);
          if (remaining == (A+1)'(1)) begin
            state     <= FLUSH;
            conv_done <= 1'b1;
          end
        end
        FLUSH: begin
          state     <= IDLE;
          conv_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_buffer_ctrl.sv
// tb/tb_neuron_buffer_ctrl.sv - vector table plus burst/contention/reset sequences with data scoreboards
module tb_neuron_buffer_ctrl;
  localparam int DEPTH = 2;
  localparam int A = 7;
  localparam int W = 16;
  localparam int D = 4;

  logic CLK, RST_N;
  logic host_req, host_we;
  logic [A-1:0] host_addr;
  logic [DEPTH-1:0] host_bank;
  logic [W-1:0] host_wdata;
  logic host_gnt, host_rvalid;
  logic [W-1:0] host_rdata;
  logic conv_start;
  logic [A-1:0] conv_base;
  logic [A:0] conv_len;
  logic conv_busy, conv_valid, conv_done;
  logic [W*D-1:0] conv_data;
  logic conv_wr;
  logic [A-1:0] conv_wr_addr;
  logic [W*D-1:0] conv_wr_data;
  logic conv_wr_ack;
  logic [W*D-1:0] buf_ip;
  logic buf_write;
  logic [A-1:0] buf_address;
  logic [W+DEPTH+1:0] buf_ioInputs;
  logic [W*D-1:0] buf_op;
  logic [W-1:0] buf_ioOutputs;

  neuron_buffer_ctrl #(.depth(DEPTH), .A(A), .W(W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_bank(host_bank),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .conv_start(conv_start), .conv_base(conv_base), .conv_len(conv_len), .conv_busy(conv_busy),
    .conv_valid(conv_valid), .conv_data(conv_data), .conv_done(conv_done),
    .conv_wr(conv_wr), .conv_wr_addr(conv_wr_addr), .conv_wr_data(conv_wr_data), .conv_wr_ack(conv_wr_ack),
    .buf_ip(buf_ip), .buf_write(buf_write), .buf_address(buf_address), .buf_ioInputs(buf_ioInputs),
    .buf_op(buf_op), .buf_ioOutputs(buf_ioOutputs)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] init_row(input int r);
    return {4{16'(r)}};
  endfunction

  function automatic logic [63:0] pat(input int r);
    return {16'hA000 | 16'(r), 16'hB000 | 16'(r), 16'hC000 | 16'(r), 16'hD000 | 16'(r)};
  endfunction

  // Synchronous buffer model: one-cycle read latency on both ports.
  logic [63:0] mem [128];
  logic mem_loaded = 1'b0;
  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int r = 0; r < 128; r++) mem[r] <= init_row(r);
      mem_loaded <= 1'b1;
    end else begin
      if (buf_ioInputs[19]) begin
        if (buf_ioInputs[18]) mem[buf_address][int'(buf_ioInputs[17:16])*16 +: 16] <= buf_ioInputs[15:0];
        buf_ioOutputs <= mem[buf_address][int'(buf_ioInputs[17:16])*16 +: 16];
      end else if (buf_write) begin
        mem[buf_address] <= buf_ip;
      end
      buf_op <= mem[buf_address];
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] conv_q [$];
  logic [15:0] host_q [$];
  logic [63:0] exp_mem [128];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (conv_valid) begin
        if (conv_q.size() == 0) check("conv_valid_unexpected", conv_valid, 0);
        else check("conv_data", conv_data, conv_q.pop_front());
      end
      if (host_rvalid) begin
        if (host_q.size() == 0) check("host_rvalid_unexpected", host_rvalid, 0);
        else check("host_rdata", host_rdata, host_q.pop_front());
      end
    end
  end

  typedef struct {
    logic cwr; logic [6:0] cwa; logic [63:0] cwd;
    logic hreq; logic hwe; logic [6:0] ha; logic [1:0] hb; logic [15:0] hwd;
    logic e_ack; logic e_gnt; logic e_write; logic [6:0] e_addr; logic [19:0] e_io; logic [63:0] e_ip;
  } vec_t;
  vec_t vecs[14];

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, host_gnt, 0);
    check({tag, "_ack"}, conv_wr_ack, 0);
    check({tag, "_write"}, buf_write, 0);
    check({tag, "_addr"}, buf_address, 0);
    check({tag, "_io"}, buf_ioInputs, 0);
    check({tag, "_busy"}, conv_busy, 0);
    check({tag, "_valid"}, conv_valid, 0);
    check({tag, "_done"}, conv_done, 0);
    check({tag, "_rvalid"}, host_rvalid, 0);
  endtask

  // Called at posedge+1 in IDLE; contend keeps host_req held and fires a second start in cycle 1.
  task automatic run_burst(input logic [6:0] base, input logic [7:0] len, input bit contend);
    int last;
    logic [6:0] ea;
    conv_start = 1'b1; conv_base = base; conv_len = len;
    for (int i = 0; i < int'(len); i++) conv_q.push_back(exp_mem[7'(int'(base) + i)]);
    @(negedge CLK);
    check("start_addr", buf_address, (len != 0) ? base : 7'd0);
    check("start_write", buf_write, 0);
    check("start_io", buf_ioInputs, 0);
    check("start_busy", conv_busy, 0);
    check("start_gnt", host_gnt, 0);
    @(posedge CLK); #1;
    conv_start = contend;
    last = (len == 0) ? 1 : int'(len);
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge CLK);
      check("burst_valid", conv_valid, (len != 0 && k <= int'(len)) ? 1 : 0);
      check("burst_done", conv_done, (k == last) ? 1 : 0);
      check("burst_busy", conv_busy, (k <= last) ? 1 : 0);
      if (k < last) begin
        ea = base + 7'(k);
        check("burst_addr", buf_address, ea);
      end
      if (contend) check("burst_host_gnt", host_gnt, (k == last + 1) ? 1 : 0);
      @(posedge CLK); #1;
      conv_start = 1'b0;
      if (contend && k == last + 1) host_req = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("post_done", conv_done, 0);
      check("post_busy", conv_busy, 0);
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wrap_rows[4];
    wrap_rows = '{126, 127, 0, 1};
    for (int r = 0; r < 128; r++) exp_mem[r] = init_row(r);
    RST_N = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'd3; host_bank = 2'd1; host_wdata = 16'h0;
    conv_start = 1'b0; conv_base = 7'd0; conv_len = 8'd0;
    conv_wr = 1'b1; conv_wr_addr = 7'd9; conv_wr_data = 64'h1;
    #3;
    check_all_zero("reset");
    host_req = 1'b0; conv_wr = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check_all_zero("idle");
    @(posedge CLK); #1;

    vecs[0] = '{1'b0, 7'd0, 64'd0, 1'b1, 1'b1, 7'd5, 2'd2, 16'hBEEF,
                1'b0, 1'b1, 1'b1, 7'd5, 20'hEBEEF, 64'd0};
    vecs[1] = '{1'b0, 7'd0, 64'd0, 1'b1, 1'b0, 7'd5, 2'd2, 16'h0000,
                1'b0, 1'b1, 1'b0, 7'd5, 20'hA0000, 64'd0};
    for (int i = 0; i < 4; i++)
      vecs[2+i] = '{1'b1, 7'(10+i), pat(10+i), 1'b0, 1'b0, 7'd0, 2'd0, 16'd0,
                    1'b1, 1'b0, 1'b1, 7'(10+i), 20'd0, pat(10+i)};
    for (int i = 0; i < 4; i++)
      vecs[6+i] = '{1'b1, 7'(wrap_rows[i]), pat(wrap_rows[i]), 1'b0, 1'b0, 7'd0, 2'd0, 16'd0,
                    1'b1, 1'b0, 1'b1, 7'(wrap_rows[i]), 20'd0, pat(wrap_rows[i])};
    vecs[10] = '{1'b1, 7'd20, pat(20), 1'b1, 1'b0, 7'd5, 2'd2, 16'd0,
                 1'b1, 1'b0, 1'b1, 7'd20, 20'd0, pat(20)};
    vecs[11] = '{1'b0, 7'd0, 64'd0, 1'b1, 1'b0, 7'd10, 2'd3, 16'd0,
                 1'b0, 1'b1, 1'b0, 7'd10, 20'hB0000, 64'd0};
    vecs[12] = '{1'b0, 7'd0, 64'd0, 1'b1, 1'b1, 7'd11, 2'd1, 16'h5A5A,
                 1'b0, 1'b1, 1'b1, 7'd11, 20'hD5A5A, 64'd0};
    vecs[13] = '{1'b0, 7'd0, 64'd0, 1'b0, 1'b0, 7'd0, 2'd0, 16'd0,
                 1'b0, 1'b0, 1'b0, 7'd0, 20'd0, 64'd0};

    for (int i = 0; i < 14; i++) begin
      conv_wr = vecs[i].cwr; conv_wr_addr = vecs[i].cwa; conv_wr_data = vecs[i].cwd;
      host_req = vecs[i].hreq; host_we = vecs[i].hwe; host_addr = vecs[i].ha;
      host_bank = vecs[i].hb; host_wdata = vecs[i].hwd;
      if (vecs[i].cwr) exp_mem[vecs[i].cwa] = vecs[i].cwd;
      else if (vecs[i].hreq) begin
        if (vecs[i].hwe) exp_mem[vecs[i].ha][int'(vecs[i].hb)*16 +: 16] = vecs[i].hwd;
        else host_q.push_back(exp_mem[vecs[i].ha][int'(vecs[i].hb)*16 +: 16]);
      end
      @(negedge CLK);
      check("vec_ack", conv_wr_ack, vecs[i].e_ack);
      check("vec_gnt", host_gnt, vecs[i].e_gnt);
      check("vec_write", buf_write, vecs[i].e_write);
      check("vec_addr", buf_address, vecs[i].e_addr);
      check("vec_io", buf_ioInputs, vecs[i].e_io);
      check("vec_ip", buf_ip, vecs[i].e_ip);
      @(posedge CLK); #1;
    end
    conv_wr = 1'b0; host_req = 1'b0;

    run_burst(7'd10, 8'd4, 1'b0);
    run_burst(7'd126, 8'd4, 1'b0);
    run_burst(7'd0, 8'd0, 1'b0);

    // All three requesters at once: write-back first, then burst, host after FLUSH.
    conv_wr = 1'b1; conv_wr_addr = 7'd30; conv_wr_data = pat(30);
    conv_start = 1'b1; conv_base = 7'd30; conv_len = 8'd1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'd30; host_bank = 2'd0; host_wdata = 16'd0;
    exp_mem[30] = pat(30);
    @(negedge CLK);
    check("simul_ack", conv_wr_ack, 1);
    check("simul_gnt", host_gnt, 0);
    check("simul_addr", buf_address, 7'd30);
    check("simul_write", buf_write, 1);
    check("simul_busy", conv_busy, 0);
    @(posedge CLK); #1;
    conv_wr = 1'b0;
    host_q.push_back(exp_mem[30][15:0]);
    run_burst(7'd30, 8'd1, 1'b1);

    host_req = 1'b1; host_we = 1'b0; host_addr = 7'd12; host_bank = 2'd2;
    host_q.push_back(exp_mem[12][47:32]);
    run_burst(7'd10, 8'd4, 1'b1);

    // Reset in the middle of an 8-row burst.
    conv_start = 1'b1; conv_base = 7'd40; conv_len = 8'd8;
    for (int i = 0; i < 8; i++) conv_q.push_back(exp_mem[40+i]);
    @(negedge CLK);
    @(posedge CLK); #1;
    conv_start = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    #1;
    host_req = 1'b1; host_addr = 7'd5; host_bank = 2'd2;
    RST_N = 1'b0;
    #1;
    check_all_zero("midreset");
    conv_q.delete();
    host_req = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("after_reset_done", conv_done, 0);
      check("after_reset_valid", conv_valid, 0);
      check("after_reset_busy", conv_busy, 0);
      @(posedge CLK); #1;
    end
    run_burst(7'd10, 8'd4, 1'b0);

    check("conv_q_empty", 64'(conv_q.size()), 0);
    check("host_q_empty", 64'(host_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
